// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared types and helpers for the round-robin mux arbiter
package mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Supports up to eight requesters; callers zero-extend narrower vectors.
  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder: first eligible index at or after ptr
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [SEL_W-1:0] winner,
  output logic             any_valid
);

  logic [NREQ-1:0]  eligible;
  logic [SEL_W-1:0] idx;

  assign eligible = req & ~mask;

  // Scan from the far end back toward ptr so the closest eligible index wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (eligible[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter with bounded hold window driving a shared mux select
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SEL_W    = sel_width(NREQ),
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             to_q, to_d;

  logic [SEL_W-1:0] owner;
  logic             own_done, own_req, at_limit, voluntary, release_o;
  logic [SEL_W-1:0] pick_ptr;
  logic [NREQ-1:0]  pick_mask;
  logic [SEL_W-1:0] winner;
  logic             any_valid;

  assign owner     = SEL_W'(onehot_to_idx(8'(gnt_q)));
  assign own_done  = done[owner];
  assign own_req   = req[owner];
  assign at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign voluntary = own_done | ~own_req;
  assign release_o = voluntary | at_limit;

  // While owning, arbitration looks ahead from the slot after the owner; a
  // voluntary release masks the owner, a pre-emption leaves it eligible.
  assign pick_ptr  = (state_q == ST_OWN) ? owner + SEL_W'(1) : ptr_q;
  assign pick_mask = (state_q == ST_OWN && voluntary) ? (ONE << owner) : '0;

  rr_pick #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req       (req),
    .ptr       (pick_ptr),
    .mask      (pick_mask),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          gnt_d   = ONE << winner;
          sel_d   = winner;
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!release_o) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = owner + SEL_W'(1);
          to_d  = ~voluntary;
          cnt_d = '0;
          if (any_valid) begin
            gnt_d = ONE << winner;
            sel_d = winner;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed vector bench for mux_arbiter (NREQ=4, MAX_HOLD=8)
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[13];

  mux_arbiter #(
    .NREQ     (4),
    .SEL_W    (2),
    .MAX_HOLD (8),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic et);
    n_total++;
    if (gnt === eg) n_pass++;
    else $display("FAIL %s gnt: got %b expected %b", name, gnt, eg);
    n_total++;
    if (sel === es) n_pass++;
    else $display("FAIL %s sel: got %0d expected %0d", name, sel, es);
    n_total++;
    if (busy === eb) n_pass++;
    else $display("FAIL %s busy: got %b expected %b", name, busy, eb);
    n_total++;
    if (timeout === et) n_pass++;
    else $display("FAIL %s timeout: got %b expected %b", name, timeout, et);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // {req, done} applied before an edge, {gnt, sel, busy, timeout} expected after it
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0010, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

    do_reset();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
    end

    // all four requesting, each owner releases after two cycles: 0,1,2,3,0 with no gap
    do_reset();
    req  = 4'b1111;
    done = 4'b0000;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
      step();
      chk($sformatf("rr_hold%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
      done = 4'(1 << (k % 4));
      step();
      done = 4'b0000;
    end
    chk("rr_wrap", 4'b0010, 2'd1, 1'b1, 1'b0);

    // owner 0 never releases: pre-empted after exactly 8 cycles, then owner 1 likewise
    do_reset();
    req = 4'b0011;
    step();
    chk("to_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("to_hold0_%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    chk("to_switch1", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("to_hold1_%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk("to_switch0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // lone requester: timeout every 8 cycles while the grant never drops
    do_reset();
    req = 4'b1000;
    step();
    chk("solo_first", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      step();
      chk($sformatf("solo_%0d", c), 4'b1000, 2'd3, 1'b1, (c % 8) == 0);
    end

    // asynchronous reset mid-grant, then arbitration restarts from ptr 0
    do_reset();
    req = 4'b0100;
    step();
    chk("ar_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0110;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_restart", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
